// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that shares one cache read port between two requesters.
// Sequences each access and stalls the response to model the miss penalty.
module cache_req_arbiter #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 11,
  parameter int L2_PENALTY  = 2,
  parameter int MEM_PENALTY = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_read,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_l1_hit,
  input  logic                  cache_l2_hit,
  output logic                  resp_valid,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_l1_hit,
  output logic                  resp_l2_hit,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  l1_hit_cnt,
  output logic [CNT_WIDTH-1:0]  l2_hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    STALL,
    RESP
  } state_e;

  localparam logic [7:0] L2P  = 8'(L2_PENALTY);
  localparam logic [7:0] MEMP = 8'(MEM_PENALTY);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_e                state_q, state_d;
  logic                  rr_last_q, rr_last_d;
  logic                  id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
  logic                  cap_l1_q, cap_l1_d;
  logic                  cap_l2_q, cap_l2_d;
  logic [7:0]            stall_q, stall_d;
  logic                  rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rl1_q, rl1_d;
  logic                  rl2_q, rl2_d;
  logic [CNT_WIDTH-1:0]  l1c_q, l1c_d;
  logic [CNT_WIDTH-1:0]  l2c_q, l2c_d;
  logic [CNT_WIDTH-1:0]  mc_q, mc_d;
  logic                  gnt0, gnt1;
  logic [7:0]            pen;

  // When both request, the one not served last wins.
  assign gnt0 = (state_q == IDLE) && req0_valid &&
                (!req1_valid || rr_last_q);
  assign gnt1 = (state_q == IDLE) && req1_valid &&
                (!req0_valid || !rr_last_q);

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign cache_addr  = addr_q;
  assign cache_read  = (state_q == ISSUE);
  assign resp_valid  = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign resp_id     = rid_q;
  assign resp_data   = rdata_q;
  assign resp_l1_hit = rl1_q;
  assign resp_l2_hit = rl2_q;
  assign l1_hit_cnt  = l1c_q;
  assign l2_hit_cnt  = l2c_q;
  assign miss_cnt    = mc_q;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    id_d       = id_q;
    addr_d     = addr_q;
    cap_data_d = cap_data_q;
    cap_l1_d   = cap_l1_q;
    cap_l2_d   = cap_l2_q;
    stall_d    = stall_q;
    rid_d      = rid_q;
    rdata_d    = rdata_q;
    rl1_d      = rl1_q;
    rl2_d      = rl2_q;
    l1c_d      = l1c_q;
    l2c_d      = l2c_q;
    mc_d       = mc_q;
    pen        = 8'd0;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          addr_d    = gnt1 ? req1_addr : req0_addr;
          id_d      = gnt1;
          rr_last_d = gnt1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        cap_data_d = cache_read_data;
        cap_l1_d   = cache_l1_hit;
        cap_l2_d   = cache_l2_hit;
        if (cache_l1_hit) begin
          pen   = 8'd0;
          l1c_d = (l1c_q == '1) ? l1c_q : l1c_q + CNT_ONE;
        end else if (cache_l2_hit) begin
          pen   = L2P;
          l2c_d = (l2c_q == '1) ? l2c_q : l2c_q + CNT_ONE;
        end else begin
          pen   = MEMP;
          mc_d  = (mc_q == '1) ? mc_q : mc_q + CNT_ONE;
        end
        stall_d = pen;
        if (pen != 8'd0) begin
          state_d = STALL;
        end else begin
          state_d = RESP;
          rid_d   = id_q;
          rdata_d = cache_read_data;
          rl1_d   = cache_l1_hit;
          rl2_d   = cache_l2_hit;
        end
      end
      STALL: begin
        stall_d = stall_q - 8'd1;
        if (stall_q == 8'd1) begin
          state_d = RESP;
          rid_d   = id_q;
          rdata_d = cap_data_q;
          rl1_d   = cap_l1_q;
          rl2_d   = cap_l2_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      id_q       <= 1'b0;
      addr_q     <= '0;
      cap_data_q <= '0;
      cap_l1_q   <= 1'b0;
      cap_l2_q   <= 1'b0;
      stall_q    <= 8'd0;
      rid_q      <= 1'b0;
      rdata_q    <= '0;
      rl1_q      <= 1'b0;
      rl2_q      <= 1'b0;
      l1c_q      <= '0;
      l2c_q      <= '0;
      mc_q       <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      cap_data_q <= cap_data_d;
      cap_l1_q   <= cap_l1_d;
      cap_l2_q   <= cap_l2_d;
      stall_q    <= stall_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rl1_q      <= rl1_d;
      rl2_q      <= rl2_d;
      l1c_q      <= l1c_d;
      l2c_q      <= l2c_d;
      mc_q       <= mc_d;
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a registered cache stub.
// Second instance covers zero L2 penalty and narrow saturating counters.
module tb_cache_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] stub_data = '0;
  logic        stub_l1 = 1'b0;
  logic        stub_l2 = 1'b0;

  logic        a_v0 = 0, a_v1 = 0;
  logic [10:0] a_ad0 = '0, a_ad1 = '0;
  logic        a_r0, a_r1, a_cr, a_rv, a_rid, a_rl1, a_rl2, a_busy;
  logic [10:0] a_ca, a_rdata;
  logic [10:0] a_cd = '0;
  logic        a_cl1 = 0, a_cl2 = 0;
  logic [15:0] a_l1c, a_l2c, a_mc;

  logic        b_v0 = 0, b_v1 = 0;
  logic [10:0] b_ad0 = '0, b_ad1 = '0;
  logic        b_r0, b_r1, b_cr, b_rv, b_rid, b_rl1, b_rl2, b_busy;
  logic [10:0] b_ca, b_rdata;
  logic [10:0] b_cd = '0;
  logic        b_cl1 = 0, b_cl2 = 0;
  logic [1:0]  b_l1c, b_l2c, b_mc;

  cache_req_arbiter u_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_addr(a_ad0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_addr(a_ad1), .req1_ready(a_r1),
    .cache_addr(a_ca), .cache_read(a_cr),
    .cache_read_data(a_cd), .cache_l1_hit(a_cl1), .cache_l2_hit(a_cl2),
    .resp_valid(a_rv), .resp_id(a_rid), .resp_data(a_rdata),
    .resp_l1_hit(a_rl1), .resp_l2_hit(a_rl2), .busy(a_busy),
    .l1_hit_cnt(a_l1c), .l2_hit_cnt(a_l2c), .miss_cnt(a_mc)
  );

  cache_req_arbiter #(.L2_PENALTY(0), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_addr(b_ad0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_addr(b_ad1), .req1_ready(b_r1),
    .cache_addr(b_ca), .cache_read(b_cr),
    .cache_read_data(b_cd), .cache_l1_hit(b_cl1), .cache_l2_hit(b_cl2),
    .resp_valid(b_rv), .resp_id(b_rid), .resp_data(b_rdata),
    .resp_l1_hit(b_rl1), .resp_l2_hit(b_rl2), .busy(b_busy),
    .l1_hit_cnt(b_l1c), .l2_hit_cnt(b_l2c), .miss_cnt(b_mc)
  );

  // Registered cache stub: outputs appear the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (a_cr) begin
      a_cd  <= stub_data;
      a_cl1 <= stub_l1;
      a_cl2 <= stub_l2;
    end
    if (b_cr) begin
      b_cd  <= stub_data;
      b_cl1 <= stub_l1;
      b_cl2 <= stub_l2;
    end
  end

  int total = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_stub(input logic [10:0] d, input logic l1,
                          input logic l2);
    stub_data = d;
    stub_l1   = l1;
    stub_l2   = l2;
  endtask

  task automatic do_req(input bit b, input bit id,
                        input logic [10:0] addr,
                        output int lat, output int rd_at,
                        output int rd_cnt, output logic [10:0] rd_addr,
                        output logic rdy);
    @(negedge clk);
    if (b) begin
      b_v0 = !id; b_v1 = id; b_ad0 = addr; b_ad1 = addr;
    end else begin
      a_v0 = !id; a_v1 = id; a_ad0 = addr; a_ad1 = addr;
    end
    #1;
    if (b) rdy = id ? b_r1 : b_r0;
    else   rdy = id ? a_r1 : a_r0;
    lat = -1; rd_at = -1; rd_cnt = 0; rd_addr = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_v0 = 0; a_v1 = 0; b_v0 = 0; b_v1 = 0;
      end
      if (b ? b_cr : a_cr) begin
        rd_cnt++;
        rd_at = n;
        rd_addr = b ? b_ca : a_ca;
      end
      if (b ? b_rv : a_rv) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat, rd_at, rd_cnt, seen;
  logic [10:0] rd_addr;
  logic rdy;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_resp_valid", a_rv, 0);
    chk("rst_cache_read", a_cr, 0);
    chk("rst_cache_addr", a_ca, 0);
    chk("rst_resp_data", a_rdata, 0);
    chk("rst_cnts", {a_l1c, a_l2c} | a_mc, 0);
    chk("rst_ready0", a_r0, 0);

    // Cold miss
    set_stub(11'h3F3, 0, 0);
    do_req(0, 0, 11'h123, lat, rd_at, rd_cnt, rd_addr, rdy);
    chk("miss_ready", rdy, 1);
    chk("miss_rd_at", rd_at, 1);
    chk("miss_rd_cnt", rd_cnt, 1);
    chk("miss_rd_addr", rd_addr, 11'h123);
    chk("miss_lat", lat, 11);
    chk("miss_id", a_rid, 0);
    chk("miss_data", a_rdata, 11'h3F3);
    chk("miss_flags", {a_rl1, a_rl2}, 2'b00);
    chk("miss_cnt", a_mc, 1);

    // L1 hit
    set_stub(11'h3F3, 1, 0);
    do_req(0, 0, 11'h123, lat, rd_at, rd_cnt, rd_addr, rdy);
    chk("l1_lat", lat, 3);
    chk("l1_flags", {a_rl1, a_rl2}, 2'b10);
    chk("l1_cnt", a_l1c, 1);

    // L2 hit through requester 1
    set_stub(11'h155, 0, 1);
    do_req(0, 1, 11'h7FF, lat, rd_at, rd_cnt, rd_addr, rdy);
    chk("l2_ready1", rdy, 1);
    chk("l2_rd_addr", rd_addr, 11'h7FF);
    chk("l2_lat", lat, 5);
    chk("l2_id", a_rid, 1);
    chk("l2_data", a_rdata, 11'h155);
    chk("l2_flags", {a_rl1, a_rl2}, 2'b01);
    chk("l2_cnt", a_l2c, 1);
    @(negedge clk);
    chk("hold_valid", a_rv, 0);
    chk("hold_data", a_rdata, 11'h155);
    chk("hold_flags", {a_rl1, a_rl2}, 2'b01);

    // Both flags high counts as L1 hit
    set_stub(11'h0AA, 1, 1);
    do_req(0, 0, 11'h010, lat, rd_at, rd_cnt, rd_addr, rdy);
    chk("both_lat", lat, 3);
    chk("both_l1cnt", a_l1c, 2);
    chk("both_l2cnt", a_l2c, 1);
    chk("both_mcnt", a_mc, 1);

    // Round robin after reset
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    set_stub(11'h001, 1, 0);
    a_v0 = 1; a_v1 = 1; a_ad0 = 11'h100; a_ad1 = 11'h200;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("rr_ready0_c%0d", i), a_r0, (i == 0 || i == 8));
      chk($sformatf("rr_ready1_c%0d", i), a_r1, (i == 4 || i == 12));
      if (i % 4 == 3) begin
        chk($sformatf("rr_resp_c%0d", i), a_rv, 1);
        chk($sformatf("rr_id_c%0d", i), a_rid, (i == 7 || i == 15));
      end
      @(negedge clk);
    end
    a_v0 = 0; a_v1 = 0;
    repeat (2) @(negedge clk);
    chk("rr_l1cnt", a_l1c, 4);

    // Reset during STALL of a miss
    set_stub(11'h2AA, 0, 0);
    a_v0 = 1; a_ad0 = 11'h2AA;
    @(negedge clk); a_v0 = 0;
    repeat (4) @(negedge clk);
    chk("stall_busy", a_busy, 1);
    chk("stall_mcnt", a_mc, 1);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    chk("srst_busy", a_busy, 0);
    chk("srst_mcnt", a_mc, 0);
    chk("srst_l1cnt", a_l1c, 0);
    chk("srst_addr", a_ca, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_rv) seen++;
    end
    chk("srst_no_resp", seen, 0);
    set_stub(11'h033, 1, 0);
    do_req(0, 0, 11'h044, lat, rd_at, rd_cnt, rd_addr, rdy);
    chk("srst_new_ready", rdy, 1);
    chk("srst_new_lat", lat, 3);
    chk("srst_new_data", a_rdata, 11'h033);

    // Zero L2 penalty, 2-bit counters
    set_stub(11'h155, 0, 1);
    do_req(1, 0, 11'h321, lat, rd_at, rd_cnt, rd_addr, rdy);
    chk("b_l2_lat", lat, 3);
    chk("b_l2_flags", {b_rl1, b_rl2}, 2'b01);
    chk("b_l2_data", b_rdata, 11'h155);
    chk("b_l2_cnt", b_l2c, 1);
    set_stub(11'h0F0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      do_req(1, 1, 11'h050, lat, rd_at, rd_cnt, rd_addr, rdy);
      if (k == 3) chk("b_l1cnt_3", b_l1c, 3);
    end
    chk("b_l1_lat", lat, 3);
    chk("b_l1_id", b_rid, 1);
    chk("b_l1cnt_sat", b_l1c, 3);
    chk("b_mcnt", b_mc, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
